// File: rtl/apb_bus_arbiter.sv
// Two-requester round-robin APB master with address-bit slave decode and a
// wait-state timeout so a hung slave completes with an error instead of locking the bus.
module apb_bus_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              r0_req,
  input  logic              r0_write,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_done,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic              r1_write,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_done,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,
  output logic              psel1,
  output logic              psel2,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata1,
  input  logic [DATA_W-1:0] prdata2,
  input  logic              pready1,
  input  logic              pready2,
  input  logic              pslverr1,
  input  logic              pslverr2,
  output logic [1:0]        dbg_state_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic              owner_q, owner_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic              elig0, elig1, grant1;
  logic              sel_hi, sel_ready, sel_err;
  logic [DATA_W-1:0] sel_rdata;
  logic              fin, fin_err;
  logic [DATA_W-1:0] fin_rdata;

  // A port whose done pulse is showing cannot win again in that same cycle.
  assign elig0  = r0_req & ~done0_q;
  assign elig1  = r1_req & ~done1_q;
  assign grant1 = elig1 & (~elig0 | ~prio_q);

  assign sel_hi    = paddr_q[ADDR_W-1];
  assign sel_ready = sel_hi ? pready2  : pready1;
  assign sel_err   = sel_hi ? pslverr2 : pslverr1;
  assign sel_rdata = sel_hi ? prdata2  : prdata1;

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    owner_d   = owner_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    cnt_d     = cnt_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    rdata0_d  = '0;
    rdata1_d  = '0;
    fin       = 1'b0;
    fin_err   = 1'b0;
    fin_rdata = '0;
    case (state_q)
      S_IDLE: begin
        if (elig0 | elig1) begin
          state_d  = S_SETUP;
          owner_d  = grant1;
          prio_d   = grant1;
          pwrite_d = grant1 ? r1_write : r0_write;
          paddr_d  = grant1 ? r1_addr  : r0_addr;
          pwdata_d = grant1 ? r1_wdata : r0_wdata;
          cnt_d    = '0;
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (sel_ready) begin
          fin       = 1'b1;
          fin_err   = sel_err;
          fin_rdata = pwrite_q ? '0 : sel_rdata;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th ACCESS cycle without ready: give up.
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (fin) begin
          state_d = S_IDLE;
          if (owner_q) begin
            done1_d  = 1'b1;
            err1_d   = fin_err;
            rdata1_d = fin_rdata;
          end else begin
            done0_d  = 1'b1;
            err0_d   = fin_err;
            rdata0_d = fin_rdata;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q  <= S_IDLE;
      prio_q   <= 1'b1;
      owner_q  <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      cnt_q    <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      cnt_q    <= cnt_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign psel1       = (state_q != S_IDLE) & ~sel_hi;
  assign psel2       = (state_q != S_IDLE) &  sel_hi;
  assign penable     = (state_q == S_ACCESS);
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign r0_done     = done0_q;
  assign r0_err      = err0_q;
  assign r0_rdata    = rdata0_q;
  assign r1_done     = done1_q;
  assign r1_err      = err1_q;
  assign r1_rdata    = rdata1_q;
  assign dbg_state_o = state_q;

endmodule
